// File: rtl/buffered_ram_reader_pkg.sv
// Shared types and constants for the burst RAM reader: FSM encoding,
// RAM read latency, skid FIFO depth, and an in-flight occupancy helper.
package buffered_ram_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int RAM_LATENCY = 2;
  localparam int SKID_DEPTH  = 4;
  localparam int SKID_PTR_W  = $clog2(SKID_DEPTH);
  localparam int SKID_CNT_W  = SKID_PTR_W + 1;

  // Number of reads still travelling through the RAM's address/data registers.
  function automatic logic [SKID_CNT_W-1:0] pipe_occupancy(input logic [RAM_LATENCY-1:0] v);
    logic [SKID_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < RAM_LATENCY; i++) begin
      n = n + SKID_CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ram_reader_fifo.sv
// Small register-based skid FIFO holding returned RAM words plus their last tag.
// The reader never pushes into a full FIFO, so push is not gated on fullness.
module ram_reader_fifo
  import buffered_ram_reader_pkg::*;
#(
  parameter int p_width = 17
) (
  input  logic                  inclk,
  input  logic                  inrst_n,
  input  logic                  in_push,
  input  logic [p_width-1:0]    in_data,
  input  logic                  in_pop,
  output logic [p_width-1:0]    out_data,
  output logic                  out_valid,
  output logic [SKID_CNT_W-1:0] out_count
);

  logic [p_width-1:0]    mem_reg [SKID_DEPTH];
  logic [SKID_PTR_W-1:0] wr_ptr_reg;
  logic [SKID_PTR_W-1:0] rd_ptr_reg;
  logic [SKID_CNT_W-1:0] count_reg;
  logic [SKID_DEPTH-1:0] wr_en;
  logic                  pop_ok;

  assign pop_ok = in_pop && (count_reg != '0);

  genvar gi;
  generate
    for (gi = 0; gi < SKID_DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = in_push && (wr_ptr_reg == SKID_PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge inclk or negedge inrst_n) begin
    if (!inrst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        if (wr_en[i]) begin
          mem_reg[i] <= in_data;
        end
      end
    end
  end

  always_ff @(posedge inclk or negedge inrst_n) begin
    if (!inrst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (in_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({in_push, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign out_data  = mem_reg[rd_ptr_reg];
  assign out_valid = (count_reg != '0);
  assign out_count = count_reg;

endmodule

// File: rtl/buffered_ram_reader.sv
// Burst read engine: walks a wrapping address range on the 2-cycle RAM read
// port and streams the words out as valid/ready beats with a last flag.
module buffered_ram_reader
  import buffered_ram_reader_pkg::*;
#(
  parameter int p_addresswidth = 4,
  parameter int p_datawidth    = 16,
  parameter int p_lenwidth     = p_addresswidth + 1
) (
  input  logic                      inclk,
  input  logic                      inrst_n,
  input  logic                      in_start,
  input  logic [p_addresswidth-1:0] in_startaddr,
  input  logic [p_lenwidth-1:0]     in_length,
  output logic                      out_busy,
  output logic                      out_done,
  output logic [p_addresswidth-1:0] out_rdaddress,
  input  logic [p_datawidth-1:0]    in_rddata,
  output logic                      out_valid,
  input  logic                      in_ready,
  output logic [p_datawidth-1:0]    out_data,
  output logic                      out_last
);

  state_t                    state_reg;
  logic [p_addresswidth-1:0] addr_reg;
  logic [p_lenwidth-1:0]     remaining_reg;
  logic                      busy_reg;
  logic                      done_reg;
  logic [RAM_LATENCY-1:0]    vp_reg;
  logic [RAM_LATENCY-1:0]    lp_reg;

  logic [SKID_CNT_W-1:0]     fifo_count;
  logic [p_datawidth:0]      fifo_dout;
  logic                      fifo_valid;
  logic [SKID_CNT_W:0]       credit_used;
  logic                      issue;
  logic                      issue_last;
  logic                      pop;
  logic                      last_pop;

  // Every word in the FIFO or still inside the RAM pipeline holds a credit.
  assign credit_used = {1'b0, fifo_count} + {1'b0, pipe_occupancy(vp_reg)};
  assign issue       = (state_reg == ST_READ) && (remaining_reg != '0) &&
                       (credit_used < (SKID_CNT_W + 1)'(SKID_DEPTH));
  assign issue_last  = issue && (remaining_reg == p_lenwidth'(1));
  assign pop         = fifo_valid && in_ready;
  assign last_pop    = pop && fifo_dout[p_datawidth];

  always_ff @(posedge inclk or negedge inrst_n) begin
    if (!inrst_n) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      vp_reg        <= '0;
      lp_reg        <= '0;
    end else begin
      done_reg <= 1'b0;
      vp_reg   <= {vp_reg[RAM_LATENCY-2:0], issue};
      lp_reg   <= {lp_reg[RAM_LATENCY-2:0], issue_last};
      case (state_reg)
        ST_IDLE: begin
          if (in_start) begin
            if (in_length != '0) begin
              addr_reg      <= in_startaddr;
              remaining_reg <= in_length;
              busy_reg      <= 1'b1;
              state_reg     <= ST_READ;
            end else begin
              done_reg <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (issue) begin
            addr_reg      <= addr_reg + 1'b1;
            remaining_reg <= remaining_reg - 1'b1;
            if (issue_last) begin
              state_reg <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (last_pop) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  ram_reader_fifo #(
    .p_width (p_datawidth + 1)
  ) u_fifo (
    .inclk     (inclk),
    .inrst_n   (inrst_n),
    .in_push   (vp_reg[RAM_LATENCY-1]),
    .in_data   ({lp_reg[RAM_LATENCY-1], in_rddata}),
    .in_pop    (pop),
    .out_data  (fifo_dout),
    .out_valid (fifo_valid),
    .out_count (fifo_count)
  );

  assign out_busy      = busy_reg;
  assign out_done      = done_reg;
  assign out_rdaddress = addr_reg;
  assign out_valid     = fifo_valid;
  assign out_data      = fifo_dout[p_datawidth-1:0];
  assign out_last      = fifo_valid && fifo_dout[p_datawidth];

endmodule

// File: tb/tb_buffered_ram_reader.sv
// Randomized bench for buffered_ram_reader: a 2-cycle RAM model feeds the DUT,
// and each burst is compared against the expected word list for its range.
module tb_buffered_ram_reader;

  localparam int AW     = 4;
  localparam int DW     = 16;
  localparam int LW     = 5;
  localparam int NWORDS = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_start = 1'b0;
  logic [AW-1:0] in_startaddr = '0;
  logic [LW-1:0] in_length = '0;
  logic          out_busy;
  logic          out_done;
  logic [AW-1:0] out_rdaddress;
  logic [DW-1:0] in_rddata;
  logic          out_valid;
  logic          in_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] ram_mem [NWORDS];
  logic [AW-1:0] ram_addr_q = '0;
  logic [DW-1:0] ram_q = '0;

  always #5 clk = ~clk;

  // Registered address then registered data: two cycles from address to q.
  always @(posedge clk) begin
    ram_addr_q <= out_rdaddress;
    ram_q      <= ram_mem[ram_addr_q];
  end
  assign in_rddata = ram_q;

  buffered_ram_reader #(
    .p_addresswidth (AW),
    .p_datawidth    (DW),
    .p_lenwidth     (LW)
  ) dut (
    .inclk         (clk),
    .inrst_n       (rst_n),
    .in_start      (in_start),
    .in_startaddr  (in_startaddr),
    .in_length     (in_length),
    .out_busy      (out_busy),
    .out_done      (out_done),
    .out_rdaddress (out_rdaddress),
    .in_rddata     (in_rddata),
    .out_valid     (out_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_last      (out_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(out_busy), 32'd0);
    check({tag, "_done"},  32'(out_done), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_last"},  32'(out_last), 32'd0);
    check({tag, "_addr"},  32'(out_rdaddress), 32'd0);
    check({tag, "_data"},  32'(out_data), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_busy",  32'(out_busy), 32'd0);
      check("idle_done",  32'(out_done), 32'd0);
    end
  endtask

  function automatic bit pick_ready(input int mode, input int bias, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return !(c >= 5 && c <= 12);
    return ($urandom_range(0, 99) < bias);
  endfunction

  // mode 0: ready always high, 1: ready low in cycles 5-12, 2: random with bias %.
  // inject: cycle in which a second start (addr 8 len 2) is attempted while busy.
  task automatic run_burst(input logic [AW-1:0] sa, input int len, input int mode,
                           input int bias, input int inject, input bit timing);
    logic [DW:0]   exp_q[$];
    logic [DW:0]   exp_beat;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [AW-1:0] prev_addr;
    int            popped;
    int            issued;
    int            last_pop_c;
    int            c;
    bit            got_done;
    bit            stall;
    bit            rdy;
    logic          is_last;

    popped = 0; issued = 0; last_pop_c = 0; got_done = 1'b0; stall = 1'b0;
    prev_data = '0; prev_last = 1'b0; prev_addr = sa;
    for (int k = 0; k < len; k++) begin
      is_last = (k == len - 1);
      exp_q.push_back({is_last, ram_mem[(int'(sa) + k) % NWORDS]});
    end

    @(negedge clk);
    in_start     = 1'b1;
    in_startaddr = sa;
    in_length    = LW'(len);
    in_ready     = pick_ready(mode, bias, 0);

    c = 1;
    while (c <= 400 && !got_done) begin
      @(negedge clk);
      if (timing) begin
        check("t_valid", 32'(out_valid), 32'(c >= 4 && c < 4 + len));
        if (c <= len) check("t_addr", 32'(out_rdaddress), 32'((int'(sa) + c - 1) % NWORDS));
      end
      if (stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data",  32'(out_data), 32'(prev_data));
        check("hold_last",  32'(out_last), 32'(prev_last));
      end
      if (c >= 2 && out_rdaddress != prev_addr) issued++;
      prev_addr = out_rdaddress;
      check("credit", 32'(issued - popped <= 4), 32'd1);

      if (out_done) begin
        got_done = 1'b1;
        check("done_cycle", 32'(c), 32'(last_pop_c + 1));
        check("done_beats", 32'(popped), 32'(len));
        check("done_busy",  32'(out_busy), 32'd0);
      end else if (len != 0) begin
        check("busy", 32'(out_busy), 32'd1);
      end else begin
        check("len0_busy", 32'(out_busy), 32'd0);
      end

      in_start = (c == inject) && out_busy;
      if (in_start) begin
        in_startaddr = AW'(8);
        in_length    = LW'(2);
      end

      rdy = pick_ready(mode, bias, c);
      in_ready = rdy;
      if (out_valid && rdy) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'd1, 32'd0);
        end else begin
          exp_beat = exp_q.pop_front();
          check("beat_data", 32'(out_data), 32'(exp_beat[DW-1:0]));
          check("beat_last", 32'(out_last), 32'(exp_beat[DW]));
          popped++;
          if (exp_beat[DW]) last_pop_c = c;
        end
      end
      stall     = out_valid && !rdy;
      prev_data = out_data;
      prev_last = out_last;
      c++;
    end
    in_start = 1'b0;
    if (!got_done) check("timeout", 32'd0, 32'd1);
    $display("burst start=%0d len=%0d mode=%0d beats=%0d cycles=%0d", sa, len, mode, popped, c - 1);
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) ram_mem[i] = DW'(16'hA000 + i);

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    idle_cycles(2);

    run_burst(AW'(3), 5, 0, 100, -1, 1'b1);
    idle_cycles(2);
    run_burst(AW'(14), 4, 0, 100, -1, 1'b1);
    idle_cycles(2);
    run_burst(AW'(0), 16, 1, 100, -1, 1'b0);
    idle_cycles(2);
    run_burst(AW'(5), 0, 0, 100, -1, 1'b0);
    idle_cycles(3);
    run_burst(AW'(3), 5, 0, 100, 2, 1'b1);
    idle_cycles(2);

    // Reset in cycle 3 of a len 8 burst, then confirm nothing leaks out.
    @(negedge clk);
    in_start = 1'b1; in_startaddr = AW'(0); in_length = LW'(8); in_ready = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(8);
    run_burst(AW'(0), 2, 0, 100, -1, 1'b1);
    idle_cycles(2);

    for (int n = 0; n < 1000; n++) begin
      ram_mem[$urandom_range(0, NWORDS - 1)] = DW'($urandom);
      run_burst(AW'($urandom_range(0, NWORDS - 1)), $urandom_range(0, 16), 2,
                $urandom_range(30, 100),
                ($urandom_range(0, 3) == 0) ? $urandom_range(2, 10) : -1, 1'b0);
      idle_cycles(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
